half_rate_rx: RTL and testbench
===============================

// Module: half_rate_rx
// PURPOSE
//  Receive side of the half-rate launch / periodic-clear register scheme, built as a
//  single-clock, scan-friendly design with no derived clocks or derived resets.
//  Captures words that a source launches every 2nd clk (din_stb) and applies the
//  source's periodic clear (clr_in) as a synchronous flush.
//  Buffers words in a small first-word-fall-through FIFO and hands them downstream
//  on a valid/ready interface. Flags overflow and strobe-phase violations.
// PARAMETERS
//  W      4  data width in bits
//  DEPTH  4  FIFO entries; power of 2, >= 2
//  CNT_W  8  width of accepted-word counter word_cnt
// PORTS
//  clk         in   1              system clock; all state updates on posedge
//  rst_n       in   1              asynchronous reset, active-low
//  din         in   W              data from half-rate source
//  din_stb     in   1              din valid this cycle (source asserts on alternate cycles)
//  clr_in      in   1              synchronous flush request (source periodic clear), 1-cycle pulse
//  dout        out  W              FIFO head word
//  dout_valid  out  1              FIFO not empty
//  dout_ready  in   1              downstream accepts dout this cycle
//  level       out  clog2(DEPTH)+1 current FIFO occupancy, 0..DEPTH
//  word_cnt    out  CNT_W          accepted pushes since reset/clr_in, wraps modulo 2^CNT_W
//  overflow    out  1              sticky: a strobed word was dropped while full
//  phase_err   out  1              sticky: din_stb high on two consecutive cycles
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - level=0, dout_valid=0, dout=0, word_cnt=0, overflow=0, phase_err=0, last_stb=0.
//   - Takes effect immediately, including mid-transfer. All FIFO contents are lost.
//  Pop
//   - pop = dout_valid & dout_ready.
//   - dout/dout_valid are registered outputs of FIFO state (FWFT).
//   - A word pushed at edge n is visible on dout with dout_valid=1 after edge n.
//   - dout is held stable while dout_valid=1 and dout_ready=0.
//   - dout_valid=0 with dout_ready=1 is a no-op.
//   - dout holds its last value when the FIFO is empty. It is not cleared.
//  Push
//   - push = din_stb & (level<DEPTH | pop).
//   - When full and pop occur in the same cycle, the push is accepted and level is unchanged.
//   - din_stb while full with no pop: word dropped, overflow<=1, word_cnt unchanged.
//   - Simultaneous push & pop when not full: level unchanged, FIFO order preserved.
//  Counter
//   - word_cnt increments by 1 per accepted push.
//   - Wraps from 2^CNT_W-1 to 0 with no flag.
//  clr_in (highest priority below reset)
//   - At the edge: level<=0, dout_valid<=0, word_cnt<=0, overflow<=0.
//   - Any same-cycle push or pop is ignored: the word is not stored and not counted.
//   - A same-cycle pop is not acknowledged; downstream must treat the word as discarded.
//   - phase_err is NOT cleared by clr_in (reset only).
//  Phase check
//   - last_stb <= din_stb every cycle.
//   - din_stb & last_stb => phase_err<=1 (sticky).
//   - The word is still handled normally (push/drop rules apply).
//   - The check is evaluated in clr_in cycles as well.
//  Storage
//   - Circular buffer with rd/wr pointers of clog2(DEPTH) bits, wrapping at DEPTH.
//   - level counter is authoritative for full/empty.
//   - No combinational path from din/din_stb to any output.
//   - One combinational path only: dout_ready -> nothing.
// TESTING (W=4, DEPTH=4, CNT_W=8)
//  1 Reset: rst_n=0 mid-stream with level=3.
//    -> all outputs 0 immediately; after release, first strobe 4'h5 appears on dout 1 edge later.
//  2 Half-rate stream: din_stb every 2nd cycle, din=1,2,3,...,8, dout_ready=1.
//    -> dout sequence 1..8, level<=1, word_cnt=8, flags 0.
//  3 Fill/overflow: dout_ready=0, strobe A,B,C,D,E.
//    -> level=4, E dropped, overflow=1, word_cnt=4.
//    Then dout_ready=1 -> dout A,B,C,D only.
//  4 Full + simultaneous pop/push: level=4, strobe 9 with dout_ready=1.
//    -> level stays 4, 9 stored last, overflow stays 0.
//  5 clr_in with level=3 and din_stb=1 same cycle.
//    -> next cycle level=0, dout_valid=0, word_cnt=0, overflow=0, strobed word absent.
//  6 Phase: din_stb high on 2 consecutive cycles.
//    -> phase_err=1, both words stored.
//    Then clr_in -> phase_err stays 1 until rst_n.
//  7 Wrap: 256 accepted pushes -> word_cnt=0; 257th -> word_cnt=1.

Source files
------------

// File: rtl/half_rate_rx_if.sv
// half_rate_rx_if
//   Bundles the signals between a half-rate source, the half_rate_rx receiver
//   and its downstream consumer.
//   Signals:
//     din / din_stb   word from the half-rate source and its strobe
//     clr_in          1-cycle synchronous flush pulse from the source
//     dout/dout_valid FIFO head word and not-empty flag (to downstream)
//     dout_ready      downstream accepts dout this cycle
//     level           FIFO occupancy 0..DEPTH
//     word_cnt        accepted pushes since reset/clr_in (wrapping)
//     overflow        sticky drop-while-full flag (cleared by clr_in)
//     phase_err       sticky back-to-back strobe flag (reset only)
//   Modports: master = source/consumer side, slave = receiver.
interface half_rate_rx_if #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]     din;
  logic             din_stb;
  logic             clr_in;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] word_cnt;
  logic             overflow;
  logic             phase_err;

  modport master (
    output din, din_stb, clr_in, dout_ready,
    input  dout, dout_valid, level, word_cnt, overflow, phase_err
  );

  modport slave (
    input  din, din_stb, clr_in, dout_ready,
    output dout, dout_valid, level, word_cnt, overflow, phase_err
  );
endinterface

// File: rtl/half_rate_rx.sv
// half_rate_rx
//   Receive side of a half-rate launch / periodic-clear scheme. Single clock,
//   no derived clocks or resets. Words strobed by the source are pushed into a
//   small first-word-fall-through FIFO and presented downstream on a
//   valid/ready interface. clr_in flushes the FIFO and counters synchronously.
//   Ports:
//     clk    system clock, all state on posedge
//     rst_n  asynchronous active-low reset
//     bus    half_rate_rx_if.slave (din, din_stb, clr_in, dout_ready in;
//            dout, dout_valid, level, word_cnt, overflow, phase_err out)
//   All outputs come straight from registers.
module half_rate_rx #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  half_rate_rx_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             overflow_q, overflow_d;
  logic             phase_err_q, phase_err_d;
  logic             last_stb_q;
  logic             push_s, pop_s, wr_en_s;

  // Next-state logic for pointers, occupancy, head register, counter and flags.
  always_comb begin
    pop_s        = dout_valid_q & bus.dout_ready;
    push_s       = bus.din_stb & ((level_q < LW'(DEPTH)) | pop_s);
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    word_cnt_d   = word_cnt_q;
    overflow_d   = overflow_q;
    wr_en_s      = 1'b0;
    // The phase check runs every cycle, clr_in cycles included.
    phase_err_d  = phase_err_q | (bus.din_stb & last_stb_q);

    if (bus.clr_in) begin
      // Flush: any same-cycle push or pop is discarded; dout keeps its value.
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      level_d      = '0;
      dout_valid_d = 1'b0;
      word_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      if (push_s) begin
        wr_en_s    = 1'b1;
        wr_ptr_d   = wr_ptr_q + AW'(1);
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end else begin
        wr_en_s    = 1'b0;
      end

      if (bus.din_stb && !push_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase

      dout_valid_d = (level_d != LW'(0));

      // The new head is the incoming word only when it lands on the slot the
      // read pointer will point at (FIFO empty after this cycle's pop).
      if (level_d != LW'(0)) begin
        if (push_s && (wr_ptr_q == rd_ptr_d)) begin
          dout_d = bus.din;
        end else begin
          dout_d = mem_q[rd_ptr_d];
        end
      end else begin
        dout_d = dout_q;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      word_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      phase_err_q  <= 1'b0;
      last_stb_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      word_cnt_q   <= word_cnt_d;
      overflow_q   <= overflow_d;
      phase_err_q  <= phase_err_d;
      last_stb_q   <= bus.din_stb;
    end
  end

  // FIFO storage; cleared on reset so no stale words survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= bus.din;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.level      = level_q;
  assign bus.word_cnt   = word_cnt_q;
  assign bus.overflow   = overflow_q;
  assign bus.phase_err  = phase_err_q;
endmodule

// File: tb/tb_half_rate_rx.sv
// tb_half_rate_rx
//   Self-checking bench for half_rate_rx (W=4, DEPTH=4, CNT_W=8).
//   A queue-based reference model tracks accepted words; the stimulus side
//   appends expected words, and an independent monitor pops and compares each
//   word the DUT hands downstream. Registered state is compared against the
//   model once per cycle.
module tb_half_rate_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  half_rate_rx_if #(.W(4), .DEPTH(4), .CNT_W(8)) bus ();

  half_rate_rx #(.W(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];
  logic [7:0] cnt_m  = 8'd0;
  logic       ovf_m  = 1'b0;
  logic       perr_m = 1'b0;
  logic       last_m = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: every handshake that completes must deliver the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.dout_valid && bus.dout_ready && !bus.clr_in) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected at %0t: got %0d expected no word", $time, bus.dout);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("pop_data", int'(bus.dout), int'(e));
      end
    end
  end

  task automatic check_state();
    chk("level", int'(bus.level), exp_q.size());
    chk("dout_valid", int'(bus.dout_valid), int'(exp_q.size() != 0));
    chk("word_cnt", int'(bus.word_cnt), int'(cnt_m));
    chk("overflow", int'(bus.overflow), int'(ovf_m));
    chk("phase_err", int'(bus.phase_err), int'(perr_m));
    if (exp_q.size() != 0) chk("dout_head", int'(bus.dout), int'(exp_q[0]));
  endtask

  // One clock cycle: check current state, drive inputs, advance the model.
  task automatic step(input logic stb, input logic [3:0] d, input logic clr, input logic rdy);
    logic popm, fullm;
    check_state();
    bus.din_stb    = stb;
    bus.din        = d;
    bus.clr_in     = clr;
    bus.dout_ready = rdy;
    popm  = (exp_q.size() != 0) && rdy;
    fullm = (exp_q.size() >= 4);
    if (stb && last_m) perr_m = 1'b1;
    last_m = stb;
    if (clr) begin
      exp_q.delete();
      cnt_m = 8'd0;
      ovf_m = 1'b0;
    end else if (stb) begin
      if (!fullm || popm) begin
        exp_q.push_back(d);
        cnt_m = cnt_m + 8'd1;
      end else begin
        ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] d, input logic rdy);
    step(1'b1, d, 1'b0, rdy);
    step(1'b0, 4'd0, 1'b0, rdy);
  endtask

  task automatic do_reset(input logic check_zero);
    check_state();
    bus.din_stb = 1'b0; bus.din = 4'd0; bus.clr_in = 1'b0; bus.dout_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    if (check_zero) begin
      chk("rst_level", int'(bus.level), 0);
      chk("rst_valid", int'(bus.dout_valid), 0);
      chk("rst_dout", int'(bus.dout), 0);
      chk("rst_cnt", int'(bus.word_cnt), 0);
      chk("rst_ovf", int'(bus.overflow), 0);
      chk("rst_perr", int'(bus.phase_err), 0);
    end
    exp_q.delete();
    cnt_m = 8'd0; ovf_m = 1'b0; perr_m = 1'b0; last_m = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.din_stb = 1'b0; bus.din = 4'd0; bus.clr_in = 1'b0; bus.dout_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // 1: reset mid-stream with three words buffered.
    strobe(4'd1, 1'b0); strobe(4'd2, 1'b0); strobe(4'd3, 1'b0);
    chk("t1_level3", int'(bus.level), 3);
    do_reset(1'b1);
    step(1'b1, 4'd5, 1'b0, 1'b1);
    chk("t1_first_dout", int'(bus.dout), 5);
    chk("t1_first_valid", int'(bus.dout_valid), 1);
    step(1'b0, 4'd0, 1'b0, 1'b1);

    // 2: half-rate stream 1..8 with downstream always ready.
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) strobe(4'(i), 1'b1);
    chk("t2_cnt", int'(bus.word_cnt), 8);
    chk("t2_empty", int'(bus.level), 0);

    // 3: fill to full, fifth word dropped, then drain.
    step(1'b0, 4'd0, 1'b1, 1'b0); step(1'b0, 4'd0, 1'b0, 1'b0);
    strobe(4'hA, 1'b0); strobe(4'hB, 1'b0); strobe(4'hC, 1'b0);
    strobe(4'hD, 1'b0); strobe(4'hE, 1'b0);
    chk("t3_level", int'(bus.level), 4);
    chk("t3_ovf", int'(bus.overflow), 1);
    chk("t3_cnt", int'(bus.word_cnt), 4);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t3_drained", int'(bus.level), 0);

    // 4: full with simultaneous pop and push.
    step(1'b0, 4'd0, 1'b1, 1'b0); step(1'b0, 4'd0, 1'b0, 1'b0);
    strobe(4'd1, 1'b0); strobe(4'd2, 1'b0); strobe(4'd3, 1'b0); strobe(4'd4, 1'b0);
    step(1'b1, 4'd9, 1'b0, 1'b1);
    chk("t4_level", int'(bus.level), 4);
    chk("t4_ovf", int'(bus.overflow), 0);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b0, 1'b1);

    // 5: clr_in together with a strobe while three words are buffered.
    strobe(4'd6, 1'b0); strobe(4'd7, 1'b0); strobe(4'd8, 1'b0);
    step(1'b1, 4'd2, 1'b1, 1'b0);
    chk("t5_level", int'(bus.level), 0);
    chk("t5_valid", int'(bus.dout_valid), 0);
    chk("t5_cnt", int'(bus.word_cnt), 0);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // 6: back-to-back strobes set phase_err; clr_in does not clear it.
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b0, 1'b0);
    chk("t6_perr", int'(bus.phase_err), 1);
    chk("t6_level", int'(bus.level), 2);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("t6_perr_kept", int'(bus.phase_err), 1);

    // 7: word counter wrap.
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) strobe(4'(i), 1'b1);
    chk("t7_wrap0", int'(bus.word_cnt), 0);
    strobe(4'hF, 1'b1);
    chk("t7_wrap1", int'(bus.word_cnt), 1);

    // Random traffic against the model.
    do_reset(1'b0);
    begin
      logic ps;
      ps = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        logic s;
        s = ps ? ($urandom_range(19) == 0) : logic'($urandom_range(1));
        step(s, 4'($urandom), logic'($urandom_range(39) == 0), logic'($urandom_range(2) != 0));
        ps = s;
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b0, 1'b1);
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
